// File: rtl/frame_uart_streamer_pkg.sv
// Shared types and constants for the frame capture / UART streamer.
//   state_e         capture + send sequencer states
//   SYNC0/1_DEFAULT default packet header bytes
//   calc_depth()    RAM depth in bytes for a given frame size and packing mode
package frame_uart_pkg;

  typedef enum logic [2:0] {
    StCapture,
    StHdr0,
    StHdr1,
    StRd,
    StRdWait,
    StPay,
    StCksum,
    StFin
  } state_e;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hAA;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h55;

  // One byte per pixel, or eight 1-bit pixels per byte when packing.
  function automatic int unsigned calc_depth(input int unsigned frame_pixels,
                                             input int unsigned pack_mode);
    return (pack_mode == 1) ? (frame_pixels / 8) : frame_pixels;
  endfunction

endpackage

// File: rtl/frame_uart_streamer_if.sv
// Canny pixel stream bundle.
//   frame_start  one-cycle pulse, restarts capture at pixel 0
//   canny_de     pixel valid
//   canny_r      pixel value
// master = pixel source (Canny filter), slave = streamer.
interface frame_uart_streamer_if #(
  parameter int unsigned PIX_W = 8
);

  logic             frame_start;
  logic             canny_de;
  logic [PIX_W-1:0] canny_r;

  modport master (output frame_start, output canny_de, output canny_r);
  modport slave  (input  frame_start, input  canny_de, input  canny_r);

endinterface

// File: rtl/frame_uart_streamer_uart_tx_core.sv
// 8N1 UART transmitter, LSB first, idle high.
//   clk, reset  clock and asynchronous active-low reset
//   start       load data when idle is high
//   data        byte to send
//   tx          serial output (registered, changes the cycle after load)
//   idle        ready for a new byte; also high in the last stop-bit cycle so
//               back-to-back bytes have no gap
module uart_tx_core #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active_q, active_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [8:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end, last_bit;

  assign bit_end  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  // bit_idx 0 = start bit, 1..8 = data, 9 = stop bit
  assign last_bit = (bit_idx_q == 4'd9);
  assign idle     = !active_q || (bit_end && last_bit);
  assign tx       = tx_q;

  always_comb begin
    active_d  = active_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (start && idle) begin
      active_d  = 1'b1;
      clk_cnt_d = '0;
      bit_idx_d = 4'd0;
      shift_d   = {1'b1, data};
      tx_d      = 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        clk_cnt_d = '0;
        if (last_bit) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end else begin
        clk_cnt_d = clk_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q  <= 1'b0;
      clk_cnt_q <= '0;
      bit_idx_q <= 4'd0;
      shift_q   <= '1;
      tx_q      <= 1'b1;
    end else begin
      active_q  <= active_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/frame_uart_streamer.sv
// Captures one Canny edge frame into RAM, then sends it over UART as
// SYNC0, SYNC1, payload (DEPTH bytes), XOR checksum of the payload.
//   clk, reset  clock and asynchronous active-low reset
//   pix         pixel stream (frame_start, canny_de, canny_r)
//   cts         host clear-to-send, asynchronous, active high
//   tx          UART serial out
//   busy        high while sending
//   frame_done  one-cycle pulse after the checksum stop bit
//   overrun     sticky; pixel arrived while sending, cleared by frame_start
module frame_uart_streamer
  import frame_uart_pkg::*;
#(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned FRAME_PIXELS = 40800,
  parameter int unsigned PACK_MODE    = 0,
  parameter int unsigned THRESH       = 128,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC0        = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1        = SYNC1_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_uart_streamer_if.slave  pix,
  input  logic                  cts,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int unsigned DEPTH = calc_depth(FRAME_PIXELS, PACK_MODE);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW    = $clog2(FRAME_PIXELS + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]    pack_q, pack_d;
  logic [AW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]    cksum_q, cksum_d;
  logic          overrun_q, overrun_d;
  logic          frame_done_q, frame_done_d;
  logic          cts_meta_q, cts_sync_q;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_q;
  logic          we;
  logic [AW-1:0] waddr, ram_addr;
  logic [7:0]    wdata;

  logic [PW-1:0] pix_idx;
  logic [7:0]    pack_base, pack_shift;
  logic          pix_bit;
  logic          tx_start, tx_idle, can_launch;
  logic [7:0]    tx_data;

  // frame_start makes the concurrent pixel (if any) pixel 0.
  assign pix_idx    = pix.frame_start ? '0 : pix_cnt_q;
  assign pack_base  = pix.frame_start ? 8'h00 : pack_q;
  assign pix_bit    = (pix.canny_r >= PIX_W'(THRESH));
  // Shift in from the top so the earliest pixel lands in bit 0 after 8 shifts.
  assign pack_shift = {pix_bit, pack_base[7:1]};
  assign can_launch = tx_idle && cts_sync_q;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    pack_d       = pack_q;
    byte_cnt_d   = byte_cnt_q;
    cksum_d      = cksum_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    we           = 1'b0;
    waddr        = AW'(pix_idx);
    wdata        = pix.canny_r[7:0];
    tx_start     = 1'b0;
    tx_data      = SYNC0;

    if (pix.canny_de && (state_q != StCapture)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StCapture: begin
        if (pix.frame_start) begin
          pix_cnt_d = '0;
          pack_d    = 8'h00;
          overrun_d = 1'b0;
        end
        if (pix.canny_de) begin
          pix_cnt_d = pix_idx + PW'(1);
          if (PACK_MODE == 1) begin
            pack_d = pack_shift;
            waddr  = AW'(pix_idx >> 3);
            wdata  = pack_shift;
            we     = (pix_idx[2:0] == 3'd7);
          end else begin
            we = 1'b1;
          end
          if (pix_idx == PW'(FRAME_PIXELS - 1)) begin
            state_d = StHdr0;
            cksum_d = 8'h00;
          end
        end
      end
      StHdr0: begin
        tx_start = can_launch;
        tx_data  = SYNC0;
        if (can_launch) state_d = StHdr1;
      end
      StHdr1: begin
        tx_start = can_launch;
        tx_data  = SYNC1;
        if (can_launch) state_d = StRd;
      end
      StRd:     state_d = StRdWait;
      StRdWait: state_d = StPay;
      StPay: begin
        tx_start = can_launch;
        tx_data  = rd_data_q;
        if (can_launch) begin
          cksum_d = cksum_q ^ rd_data_q;
          if (byte_cnt_q == AW'(DEPTH - 1)) begin
            state_d = StCksum;
          end else begin
            byte_cnt_d = byte_cnt_q + AW'(1);
            state_d    = StRd;
          end
        end
      end
      StCksum: begin
        tx_start = can_launch;
        tx_data  = cksum_q;
        if (can_launch) state_d = StFin;
      end
      StFin: begin
        // Wait for the checksum stop bit to finish before reporting done.
        if (tx_idle) begin
          frame_done_d = 1'b1;
          pix_cnt_d    = '0;
          pack_d       = 8'h00;
          byte_cnt_d   = '0;
          state_d      = StCapture;
        end
      end
      default: state_d = StCapture;
    endcase
  end

  assign ram_addr = (state_q == StCapture) ? waddr : byte_cnt_q;

  always_ff @(posedge clk) begin
    if (we) mem[ram_addr] <= wdata;
    rd_data_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StCapture;
      pix_cnt_q    <= '0;
      pack_q       <= 8'h00;
      byte_cnt_q   <= '0;
      cksum_q      <= 8'h00;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      cts_meta_q   <= 1'b0;
      cts_sync_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      pack_q       <= pack_d;
      byte_cnt_q   <= byte_cnt_d;
      cksum_q      <= cksum_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      cts_meta_q   <= cts;
      cts_sync_q   <= cts_meta_q;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_core (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (tx_data),
    .tx    (tx),
    .idle  (tx_idle)
  );

  assign busy       = (state_q != StCapture);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Bench for frame_uart_streamer: one unpacked and one packed instance, a UART
// receiver that decodes tx mid-bit and compares against a queue of expected bytes.
module tb_frame_uart_streamer;

  localparam int unsigned FP = 16;
  localparam int unsigned CB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, cts0, cts1;
  logic tx0, tx1, busy0, busy1, fd0, fd1, ovr0, ovr1;

  frame_uart_streamer_if #(.PIX_W(8)) pix0 ();
  frame_uart_streamer_if #(.PIX_W(8)) pix1 ();

  frame_uart_streamer #(
    .PIX_W(8), .FRAME_PIXELS(FP), .PACK_MODE(0), .THRESH(128),
    .CLKS_PER_BIT(CB), .SYNC0(8'hAA), .SYNC1(8'h55)
  ) dut0 (
    .clk(clk), .reset(rst0_n), .pix(pix0), .cts(cts0), .tx(tx0),
    .busy(busy0), .frame_done(fd0), .overrun(ovr0)
  );

  frame_uart_streamer #(
    .PIX_W(8), .FRAME_PIXELS(FP), .PACK_MODE(1), .THRESH(128),
    .CLKS_PER_BIT(CB), .SYNC0(8'hAA), .SYNC1(8'h55)
  ) dut1 (
    .clk(clk), .reset(rst1_n), .pix(pix1), .cts(cts1), .tx(tx1),
    .busy(busy1), .frame_done(fd1), .overrun(ovr1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] px_buf[FP];

  logic mon_sel;
  logic cur_tx, cur_busy, cur_fd, cur_rst;
  assign cur_tx   = mon_sel ? tx1 : tx0;
  assign cur_busy = mon_sel ? busy1 : busy0;
  assign cur_fd   = mon_sel ? fd1 : fd0;
  assign cur_rst  = mon_sel ? rst1_n : rst0_n;

  int cyc = 0;
  int done_cnt = 0;
  int rx_starts = 0;
  int rx_bytes = 0;
  int last_start_cyc = 0;
  int snap_done, snap_bytes, snap_starts;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cur_fd) done_cnt <= done_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples each bit near its centre; abandons a byte on reset.
  initial begin : rx_mon
    logic [7:0] data;
    logic       abort;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (cur_rst && cur_tx == 1'b0) begin
        rx_starts++;
        last_start_cyc = cyc;
        abort = 1'b0;
        data  = 8'h00;
        check_val("busy_in_byte", cur_busy, 1);
        for (int k = 0; k < CB / 2 - 1 && !abort; k++) begin
          @(negedge clk);
          if (!cur_rst) abort = 1'b1;
        end
        if (!abort) check_val("start_bit", cur_tx, 0);
        for (int b = 0; b < 9 && !abort; b++) begin
          for (int k = 0; k < CB && !abort; k++) begin
            @(negedge clk);
            if (!cur_rst) abort = 1'b1;
          end
          if (!abort) begin
            if (b < 8) data[b] = cur_tx;
            else check_val("stop_bit", cur_tx, 1);
          end
        end
        if (!abort) begin
          rx_bytes++;
          check_val("rx_queue_nonempty", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check_val("rx_byte", data, exp_b);
          end
        end
      end
    end
  end

  task automatic drive_pix(input logic sel, input logic fs, input logic de, input logic [7:0] val);
    @(negedge clk);
    if (sel == 1'b0) begin
      pix0.frame_start = fs; pix0.canny_de = de; pix0.canny_r = val;
    end else begin
      pix1.frame_start = fs; pix1.canny_de = de; pix1.canny_r = val;
    end
  endtask

  task automatic send_frame(input logic sel, input logic fs_first);
    for (int i = 0; i < FP; i++) drive_pix(sel, fs_first && (i == 0), 1'b1, px_buf[i]);
    drive_pix(sel, 1'b0, 1'b0, 8'h00);
  endtask

  // Expected packet from px_buf: header, payload, XOR of payload.
  task automatic push_expected(input logic packed_mode);
    logic [7:0] ck, b;
    ck = 8'h00;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    if (packed_mode) begin
      for (int j = 0; j < FP / 8; j++) begin
        b = 8'h00;
        for (int k = 0; k < 8; k++) b[k] = (px_buf[j * 8 + k] >= 8'd128);
        exp_q.push_back(b);
        ck = ck ^ b;
      end
    end else begin
      for (int i = 0; i < FP; i++) begin
        exp_q.push_back(px_buf[i]);
        ck = ck ^ px_buf[i];
      end
    end
    exp_q.push_back(ck);
  endtask

  task automatic begin_frame();
    snap_done   = done_cnt;
    snap_bytes  = rx_bytes;
    snap_starts = rx_starts;
  endtask

  task automatic wait_frame(input int n_bytes, input string tag);
    for (int t = 0; t < 6000 && !(exp_q.size() == 0 && done_cnt > snap_done); t++)
      @(negedge clk);
    repeat (20) @(negedge clk);
    check_val({tag, "_done_pulses"}, done_cnt - snap_done, 1);
    check_val({tag, "_byte_count"}, rx_bytes - snap_bytes, n_bytes);
    check_val({tag, "_leftover"}, exp_q.size(), 0);
    check_val({tag, "_busy_after"}, cur_busy, 0);
    check_val({tag, "_tx_idle"}, cur_tx, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int gap;
    rst0_n = 1'b0; rst1_n = 1'b0; cts0 = 1'b1; cts1 = 1'b1; mon_sel = 1'b0;
    pix0.frame_start = 1'b0; pix0.canny_de = 1'b0; pix0.canny_r = 8'h00;
    pix1.frame_start = 1'b0; pix1.canny_de = 1'b0; pix1.canny_r = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_tx0", tx0, 1);     check_val("rst_tx1", tx1, 1);
    check_val("rst_busy0", busy0, 0); check_val("rst_busy1", busy1, 0);
    check_val("rst_fd0", fd0, 0);     check_val("rst_fd1", fd1, 0);
    check_val("rst_ovr0", ovr0, 0);   check_val("rst_ovr1", ovr1, 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (4) @(negedge clk);

    // Unpacked frame 01..10
    for (int i = 0; i < FP; i++) px_buf[i] = 8'(i + 1);
    begin_frame(); push_expected(1'b0); send_frame(1'b0, 1'b0);
    wait_frame(19, "mode0");

    // Packed frame, alternating FF/00
    mon_sel = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < FP; i++) px_buf[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    begin_frame(); push_expected(1'b1); send_frame(1'b1, 1'b0);
    wait_frame(5, "mode1");
    mon_sel = 1'b0;
    repeat (2) @(negedge clk);

    // CTS dropped during the third byte
    for (int i = 0; i < FP; i++) px_buf[i] = 8'(8'h20 + i * 3);
    begin_frame(); push_expected(1'b0); send_frame(1'b0, 1'b0);
    for (int t = 0; t < 2000 && rx_starts < snap_starts + 3; t++) @(negedge clk);
    cts0 = 1'b0;
    repeat (500) @(negedge clk);
    check_val("cts_hold_starts", rx_starts - snap_starts, 3);
    cts0 = 1'b1;
    gap = cyc;
    for (int t = 0; t < 200 && rx_starts < snap_starts + 4; t++) @(negedge clk);
    gap = last_start_cyc - gap;
    check_val("cts_resume_gap_ok", (gap >= 2 && gap <= 4), 1);
    wait_frame(19, "cts");

    // Pixel and frame_start during SEND are ignored; overrun is sticky
    for (int i = 0; i < FP; i++) px_buf[i] = 8'(8'h40 ^ (i * 9));
    begin_frame(); push_expected(1'b0); send_frame(1'b0, 1'b0);
    for (int t = 0; t < 2000 && rx_starts < snap_starts + 2; t++) @(negedge clk);
    drive_pix(1'b0, 1'b0, 1'b1, 8'hEE);
    drive_pix(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("overrun_set", ovr0, 1);
    drive_pix(1'b0, 1'b1, 1'b0, 8'h00);
    drive_pix(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("overrun_sticky_in_send", ovr0, 1);
    wait_frame(19, "overrun");
    check_val("overrun_after_frame", ovr0, 1);
    drive_pix(1'b0, 1'b1, 1'b0, 8'h00);
    drive_pix(1'b0, 1'b0, 1'b0, 8'h00);
    check_val("overrun_cleared", ovr0, 0);

    // Partial frame then resync
    for (int i = 0; i < 5; i++) drive_pix(1'b0, 1'b0, 1'b1, 8'(8'h11 + i));
    drive_pix(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < FP; i++) px_buf[i] = 8'(8'hA0 + i);
    begin_frame(); push_expected(1'b0); send_frame(1'b0, 1'b0);
    wait_frame(19, "resync");

    // Reset while a payload start bit is on the wire
    for (int i = 0; i < FP; i++) px_buf[i] = 8'(i * 7 + 3);
    begin_frame(); push_expected(1'b0); send_frame(1'b0, 1'b0);
    for (int t = 0; t < 2000 && rx_starts < snap_starts + 4; t++) @(negedge clk);
    for (int t = 0; t < 100 && tx0 != 1'b0; t++) @(negedge clk);
    check_val("tx_low_before_reset", tx0, 0);
    rst0_n = 1'b0;
    #1;
    check_val("reset_tx_immediate", tx0, 1);
    check_val("reset_busy", busy0, 0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check_val("reset_fd", fd0, 0);
    rst0_n = 1'b1;
    repeat (3) @(negedge clk);
    // frame_start coincides with pixel 0
    for (int i = 0; i < FP; i++) px_buf[i] = 8'(8'hC3 ^ (i * 5));
    begin_frame(); push_expected(1'b0); send_frame(1'b0, 1'b1);
    wait_frame(19, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
